// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        WAIT,
        DRAIN
    } state_t;

    localparam logic [7:0] DEFAULT_READ_CMD = 8'h03;

    // Number of bytes carried by one engine transfer for a given len flag.
    function automatic logic [16:0] xfer_count(input logic two);
        return two ? 17'd2 : 17'd1;
    endfunction

endpackage

// File: rtl/spi_flash_rbuf.sv
// Two-byte read buffer: loaded with one or two bytes, drained byte-serially over valid/ready.
module spi_flash_rbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        load_two,
    input  logic        load_last,
    input  logic [15:0] load_data,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        empty,
    output logic        one_left
);

    logic [7:0] byte0;
    logic [1:0] count;
    logic       last_q;

    assign empty    = (count == 2'd0);
    assign one_left = (count == 2'd1);

    // Loads only happen while empty, so load and pop never coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= 2'd0;
            byte0   <= 8'h00;
            last_q  <= 1'b0;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (load) begin
            m_valid <= 1'b1;
            last_q  <= load_last;
            byte0   <= load_data[7:0];
            if (load_two) begin
                count  <= 2'd2;
                m_data <= load_data[15:8];
                m_last <= 1'b0;
            end else begin
                count  <= 2'd1;
                m_data <= load_data[7:0];
                m_last <= load_last;
            end
        end else if (m_valid && m_ready) begin
            if (count == 2'd2) begin
                count  <= 2'd1;
                m_data <= byte0;
                m_last <= last_q;
            end else begin
                count   <= 2'd0;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spi_flash_reader.sv
// Sequences opcode, address and data transfers on an SPI byte engine and streams read bytes out.
module spi_flash_reader
    import spi_flash_pkg::*;
#(
    parameter logic [7:0] READ_CMD  = DEFAULT_READ_CMD,
    parameter int         ADDR_BITS = 24
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] s_addr,
    input  logic [15:0]          s_size,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [7:0]           m_data,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_spi_last,
    output logic                 m_spi_len,
    output logic [15:0]          m_spi_wdata,
    output logic                 m_spi_valid,
    input  logic                 m_spi_ready,
    input  logic [15:0]          s_spi_rdata,
    input  logic                 s_spi_rvalid,
    output logic                 busy
);

    state_t               state;
    state_t               after_wait;
    logic [ADDR_BITS-1:0] addr_q;
    logic [16:0]          remaining;
    logic                 buf_load;
    logic                 buf_empty;
    logic                 buf_one_left;
    logic                 pop_final;

    assign s_ready   = (state == IDLE);
    assign busy      = (state != IDLE);
    assign buf_load  = (state == WAIT) && s_spi_rvalid && (after_wait == DRAIN);
    // The buffer goes empty on this edge; leave DRAIN now rather than a cycle later.
    assign pop_final = m_valid && m_ready && buf_one_left;

    spi_flash_rbuf u_rbuf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .load_two  (m_spi_len),
        .load_last (m_spi_last),
        .load_data (s_spi_rdata),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .empty     (buf_empty),
        .one_left  (buf_one_left)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            after_wait  <= IDLE;
            addr_q      <= '0;
            remaining   <= 17'd0;
            m_spi_valid <= 1'b0;
            m_spi_last  <= 1'b0;
            m_spi_len   <= 1'b0;
            m_spi_wdata <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        addr_q    <= s_addr;
                        remaining <= {1'b0, s_size} + 17'd1;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    if (m_spi_ready) begin
                        m_spi_valid <= 1'b1;
                        m_spi_wdata <= {READ_CMD, addr_q[23:16]};
                        m_spi_len   <= 1'b1;
                        m_spi_last  <= 1'b0;
                        after_wait  <= ADDR;
                        state       <= WAIT;
                    end
                end
                ADDR: begin
                    if (m_spi_ready) begin
                        m_spi_valid <= 1'b1;
                        m_spi_wdata <= {addr_q[15:8], addr_q[7:0]};
                        m_spi_len   <= 1'b1;
                        m_spi_last  <= 1'b0;
                        after_wait  <= DATA;
                        state       <= WAIT;
                    end
                end
                DATA: begin
                    if (m_spi_ready) begin
                        m_spi_valid <= 1'b1;
                        m_spi_wdata <= 16'h0000;
                        m_spi_len   <= (remaining >= 17'd2);
                        m_spi_last  <= (remaining <= 17'd2);
                        after_wait  <= DRAIN;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_spi_valid && m_spi_ready) begin
                        m_spi_valid <= 1'b0;
                    end
                    if (s_spi_rvalid) begin
                        m_spi_valid <= 1'b0;
                        state       <= after_wait;
                        if (after_wait == DRAIN) begin
                            remaining <= remaining - xfer_count(m_spi_len);
                        end
                    end
                end
                DRAIN: begin
                    if (buf_empty || pop_final) begin
                        state <= (remaining == 17'd0) ? IDLE : DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_flash_reader.md
SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 SHALL have parameter READ_CMD, default 8'h03, meaning the flash read opcode.
REQ-002 SHALL have parameter ADDR_BITS, default 24, meaning the flash address width (24 only is supported).
REQ-003 SHALL have ports:
- reset  in  1  synchronous, active-high reset
- clk  in  1  single clock; all logic on posedge clk
- s_addr  in  24  start byte address
- s_size  in  16  byte count minus 1 (1..65536 bytes)
- s_valid  in  1  command request
- s_ready  out  1  command accept
- m_data  out  8  read byte
- m_last  out  1  final byte of the command
- m_valid  out  1  byte valid
- m_ready  in  1  byte accept
- m_spi_last  out  1  deassert CS after this transfer
- m_spi_len  out  1  0 = 1 byte, 1 = 2 bytes
- m_spi_wdata  out  2x8  [1] sent first, then [0]
- m_spi_valid  out  1  transfer request to the byte engine
- m_spi_ready  in  1  engine idle
- s_spi_rdata  in  2x8  received bytes: 2-byte transfer [1] first, [0] second; 1-byte transfer uses [0]
- s_spi_rvalid  in  1  one-cycle pulse, transfer complete
- busy  out  1  command in progress

Function
REQ-004 SHALL accept a command when s_valid && s_ready; s_ready = (state == IDLE); s_addr and s_size are latched on acceptance.
REQ-005 SHALL use the FSM states IDLE, CMD, ADDR, DATA, WAIT, DRAIN.
REQ-006 CMD SHALL issue {READ_CMD, addr[23:16]} with len=1, last=0, then go to WAIT.
REQ-007 ADDR SHALL issue {addr[15:8], addr[7:0]} with len=1, last=0, then go to WAIT.
REQ-008 DATA SHALL issue wdata={8'h00, 8'h00} with:
- len=1 if remaining >= 2, otherwise len=0
- last=1 iff this transfer contains the final byte
REQ-009 SHALL assert m_spi_valid only when m_spi_ready=1.
REQ-010 SHALL hold m_spi_valid for exactly one cycle per transfer, deasserting it the cycle after m_spi_valid && m_spi_ready.
REQ-011 WAIT SHALL ignore m_spi_ready and advance only on s_spi_rvalid:
- after CMD, go to ADDR
- after ADDR, go to DATA
- after DATA, go to DRAIN
REQ-012 rdata from CMD and ADDR transfers SHALL be discarded.
REQ-013 On a DATA completion, the 1 or 2 received bytes SHALL be captured into a 2-byte output buffer and remaining decremented by the captured count.
REQ-014 DRAIN SHALL present buffered bytes in order ([1] then [0] for 2-byte; [0] for 1-byte).
REQ-015 The next DATA transfer SHALL NOT be issued until the buffer is empty, so no read byte is lost under m_ready backpressure.
REQ-016 m_data/m_valid/m_last SHALL be stable while m_valid && !m_ready.
REQ-017 m_last SHALL be 1 only on the final byte of the command.
REQ-018 After the final byte is accepted, the FSM SHALL return to IDLE; s_ready=1 the next cycle.
REQ-019 remaining SHALL be a 17-bit counter initialised to s_size+1; arithmetic SHALL be unsigned with no wrap; s_size=16'hFFFF yields 65536 bytes.
REQ-020 The address SHALL NOT be incremented by this block; the flash auto-increments.
REQ-021 s_valid while busy SHALL be ignored (not queued).
REQ-022 busy = (state != IDLE).
REQ-023 s_spi_rvalid in IDLE SHALL be ignored.

Reset
REQ-024 On reset:
- state=IDLE; s_ready=1; busy=0
- m_valid=0; m_last=0; m_data=0
- m_spi_valid=0; m_spi_last=0; m_spi_len=0; m_spi_wdata=0
- buffer count=0
REQ-025 Reset mid-operation SHALL abort the command with no further m_valid; the engine is reset by the same reset.

Structure
REQ-026 Package spi_flash_pkg SHALL hold the state enum type and the default READ_CMD constant.
REQ-027 The 2-byte output buffer SHALL be sub-module spi_flash_rbuf (load 1/2 bytes, byte-serial valid/ready out, empty flag).

Verification
REQ-028 Bench SHALL cover these directed scenarios:
- addr=24'h123456, size=0 -> engine transfers {03,12}/len1/last0, {34,56}/len1/last0, {00,00}/len0/last1; one m_data with m_last=1.
- size=3 -> two DATA transfers len1, len1 (last on 2nd); 4 bytes out in order [1],[0],[1],[0]; m_last on 4th.
- size=2 -> DATA len1 last0 then len0 last1; 3 bytes out.
- m_ready held 0 for 100 cycles with 2 bytes buffered -> no m_spi_valid issued, outputs stable, no byte lost.
- s_valid pulsed during DATA -> ignored; s_ready=0 until final byte accepted.
- reset asserted in WAIT of 2nd DATA transfer -> next cycle all outputs at reset values, s_ready=1; a new command then completes normally.
